// File: rtl/display_page_scheduler_pkg.sv
// Shared definitions for the display page scheduler: FSM state encoding and
// board-level default parameters (25 MHz board clock).
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  localparam int N_PAGES_DEF      = 4;
  localparam int DATA_W_DEF       = 16;
  localparam int DWELL_CYCLES_1S  = 25_000_000;
  localparam int BLANK_CYCLES_DEF = 2_500_000;

endpackage

// File: rtl/display_page_scheduler_if.sv
// Bus between the page sources and the display driver.
// slave  : the scheduler (consumes pages/controls, produces the display word)
// master : the surrounding logic (drives pages/controls, observes the display)
interface display_page_scheduler_if #(
  parameter int N_PAGES = 4,
  parameter int DATA_W  = 16
) ();
  localparam int IDX_W = $clog2(N_PAGES);

  logic [N_PAGES*DATA_W-1:0] page_data;
  logic [N_PAGES-1:0]        page_en;
  logic                      hold;
  logic                      next_pulse;
  logic [DATA_W-1:0]         disp_data;
  logic [IDX_W-1:0]          disp_idx;
  logic                      disp_valid;
  logic                      page_tick;

  modport slave (
    input  page_data, page_en, hold, next_pulse,
    output disp_data, disp_idx, disp_valid, page_tick
  );

  modport master (
    output page_data, page_en, hold, next_pulse,
    input  disp_data, disp_idx, disp_valid, page_tick
  );
endinterface

// File: rtl/display_page_scheduler_rr_next_finder.sv
// Combinational round-robin search: first enabled page strictly after idx,
// wrapping modulo N_PAGES; falls back to idx itself when it is the only one.
module rr_next_finder #(
  parameter int N_PAGES = 4,
  parameter int IDX_W   = 2
) (
  input  logic [N_PAGES-1:0] page_en,
  input  logic [IDX_W-1:0]   idx,
  output logic [IDX_W-1:0]   next_idx,
  output logic               any_en
);

  logic [IDX_W:0] cand;

  // Scan offsets from farthest to nearest so the nearest enabled page wins.
  always_comb begin
    next_idx = idx;
    any_en   = |page_en;
    cand     = '0;
    for (int k = N_PAGES; k >= 1; k--) begin
      cand = {1'b0, idx} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_PAGES)) begin
        cand = cand - (IDX_W+1)'(N_PAGES);
      end else begin
        cand = cand;
      end
      if (page_en[cand[IDX_W-1:0]]) begin
        next_idx = cand[IDX_W-1:0];
      end else begin
        next_idx = next_idx;
      end
    end
  end

endmodule

// File: rtl/display_page_scheduler.sv
// Round-robin page scheduler for a shared display datapath.
// Optional feature macro: DISPLAY_BLANK_EN (blank gap between pages).
module display_page_scheduler
  import display_pkg::*;
#(
  parameter int N_PAGES      = N_PAGES_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DWELL_CYCLES = DWELL_CYCLES_1S,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input logic                      clk,
  input logic                      reset_n,
  display_page_scheduler_if.slave  bus
);

  localparam int IDX_W = $clog2(N_PAGES);
  localparam int CNT_W = $clog2(DWELL_CYCLES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               tick_q, tick_d;

  logic [IDX_W-1:0]   search_idx_s;
  logic [IDX_W-1:0]   next_idx_s;
  logic               any_en_s;
  logic               advance_s;
  logic [DATA_W-1:0]  sel_data_s;

`ifdef DISPLAY_BLANK_EN
  localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
  logic [BLK_W-1:0]   bcnt_q, bcnt_d;
`endif

  // From IDLE search from the last index so the wrap lands on the lowest enabled page.
  assign search_idx_s = (state_q == ST_IDLE) ? IDX_W'(N_PAGES - 1) : idx_q;

  rr_next_finder #(
    .N_PAGES (N_PAGES),
    .IDX_W   (IDX_W)
  ) u_next (
    .page_en  (bus.page_en),
    .idx      (search_idx_s),
    .next_idx (next_idx_s),
    .any_en   (any_en_s)
  );

  // Advance on manual pulse, on dwell expiry (frozen by hold) or when the shown page drops out.
  assign advance_s = bus.next_pulse || !bus.page_en[idx_q] ||
                     (!bus.hold && (cnt_q == CNT_W'(DWELL_CYCLES - 1)));

  // Next-state logic: page rotation, dwell counting and blank gap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
`ifdef DISPLAY_BLANK_EN
    bcnt_d  = bcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_en_s) begin
          state_d = ST_SHOW;
          idx_d   = next_idx_s;
          cnt_d   = '0;
          tick_d  = 1'b1;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (!any_en_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (advance_s) begin
          idx_d   = next_idx_s;
          cnt_d   = '0;
`ifdef DISPLAY_BLANK_EN
          state_d = ST_BLANK;
          bcnt_d  = '0;
`else
          tick_d  = 1'b1;
`endif
        end else if (!bus.hold) begin
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = cnt_q;
        end
      end
`ifdef DISPLAY_BLANK_EN
      ST_BLANK: begin
        if (!any_en_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (bus.next_pulse || (!bus.hold && (bcnt_q == BLK_W'(BLANK_CYCLES - 1)))) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          tick_d  = 1'b1;
        end else if (!bus.hold) begin
          bcnt_d  = bcnt_q + BLK_W'(1);
        end else begin
          bcnt_d  = bcnt_q;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Word of the page that will be shown next cycle (live update while showing).
  always_comb begin
    sel_data_s = '0;
    for (int k = 0; k < N_PAGES; k++) begin
      if (idx_d == IDX_W'(k)) begin
        sel_data_s = bus.page_data[k*DATA_W +: DATA_W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Display outputs follow the next state: valid data only while showing.
  always_comb begin
    valid_d = (state_d == ST_SHOW);
    if (valid_d) begin
      data_d = sel_data_s;
    end else begin
      data_d = '0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
`ifdef DISPLAY_BLANK_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
`ifdef DISPLAY_BLANK_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign bus.disp_data  = data_q;
  assign bus.disp_idx   = idx_q;
  assign bus.disp_valid = valid_q;
  assign bus.page_tick  = tick_q;

endmodule

// File: tb/tb_display_page_scheduler.sv
// Randomized self-checking bench for display_page_scheduler against a
// behavioural model of the page rotation rules.
module tb_display_page_scheduler;

  localparam int NP    = 4;
  localparam int DW    = 16;
  localparam int DWELL = 8;
  localparam int BLANK = 2;

  localparam int M_IDLE  = 0;
  localparam int M_SHOW  = 1;
  localparam int M_BLANK = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  display_page_scheduler_if #(.N_PAGES(NP), .DATA_W(DW)) bus ();

  display_page_scheduler #(
    .N_PAGES      (NP),
    .DATA_W       (DW),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_cnt = 0;

  // model state
  int          m_state;
  int          m_idx;
  int          m_elapsed;
  int          m_bleft;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_tick;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int first_enabled(input logic [NP-1:0] en);
    for (int i = 0; i < NP; i++) if (en[i]) return i;
    return 0;
  endfunction

  function automatic int next_after(input logic [NP-1:0] en, input int from);
    for (int s = 1; s <= NP; s++) if (en[(from + s) % NP]) return (from + s) % NP;
    return from;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_idx = 0; m_elapsed = 0; m_bleft = 0;
    m_data = 16'h0000; m_valid = 1'b0; m_tick = 1'b0;
  endtask

  // Apply one clock of the scheduling rules using the inputs present at the edge.
  task automatic model_clock();
    logic [NP-1:0] en;
    en = bus.page_en;
    m_tick = 1'b0;
    if (en == '0) begin
      m_state = M_IDLE;
    end else if (m_state == M_IDLE) begin
      m_idx = first_enabled(en); m_elapsed = 0; m_state = M_SHOW; m_tick = 1'b1;
    end else if (m_state == M_SHOW) begin
      if (bus.next_pulse || !en[m_idx] || (!bus.hold && m_elapsed == DWELL - 1)) begin
        m_idx = next_after(en, m_idx); m_elapsed = 0;
`ifdef DISPLAY_BLANK_EN
        m_state = M_BLANK; m_bleft = BLANK;
`else
        m_tick = 1'b1;
`endif
      end else if (!bus.hold) begin
        m_elapsed++;
      end
    end else begin
      if (bus.next_pulse || (!bus.hold && m_bleft == 1)) begin
        m_state = M_SHOW; m_elapsed = 0; m_tick = 1'b1;
      end else if (!bus.hold) begin
        m_bleft--;
      end
    end
    m_valid = (m_state == M_SHOW);
    m_data  = m_valid ? bus.page_data[m_idx*DW +: DW] : 16'h0000;
  endtask

  task automatic compare(input string where);
    check({where, ".idx"},   32'(bus.disp_idx),   32'(m_idx));
    check({where, ".data"},  32'(bus.disp_data),  32'(m_data));
    check({where, ".valid"}, 32'(bus.disp_valid), 32'(m_valid));
    check({where, ".tick"},  32'(bus.page_tick),  32'(m_tick));
  endtask

  task automatic step(input string where);
    @(posedge clk);
    model_clock();
    #1;
    if (bus.page_tick) tick_cnt++;
    compare(where);
  endtask

  task automatic run(input string where, input int n);
    for (int i = 0; i < n; i++) step(where);
  endtask

  task automatic wait_show_idx(input int target, input int bound);
    logic found;
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (m_state == M_SHOW && m_idx == target) begin
        found = 1'b1;
        break;
      end
      step("wait_idx");
    end
    check("wait_idx_bound", 32'(found), 32'd1);
  endtask

  task automatic wait_expiry(input int bound);
    logic found;
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (m_state == M_SHOW && m_elapsed == DWELL - 1) begin
        found = 1'b1;
        break;
      end
      step("wait_exp");
    end
    check("wait_expiry_bound", 32'(found), 32'd1);
  endtask

  task automatic set_pages_default();
    for (int k = 0; k < NP; k++) bus.page_data[k*DW +: DW] = 16'hA000 + 16'(k);
  endtask

  initial begin
    bus.page_en = '0; bus.hold = 1'b0; bus.next_pulse = 1'b0;
    set_pages_default();
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    compare("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // full rotation
    bus.page_en = 4'b1111;
    tick_cnt = 0;
    run("rot1111", 40);
`ifndef DISPLAY_BLANK_EN
    check("ticks_in_40", 32'(tick_cnt), 32'd5);
`endif

    // sparse enable
    bus.page_en = 4'b0101;
    run("rot0101", 30);

    // hold at idx 1, then manual advance during hold
    bus.page_en = 4'b1111;
    wait_show_idx(1, 60);
    bus.hold = 1'b1;
    run("hold", 20);
    bus.next_pulse = 1'b1;
    step("np_hold");
    bus.next_pulse = 1'b0;
    bus.hold = 1'b0;
    run("after_hold", 4);

    // manual pulse exactly on expiry
    wait_expiry(40);
    bus.next_pulse = 1'b1;
    step("np_expiry");
    bus.next_pulse = 1'b0;
    run("after_exp", 4);

    // drop the shown page, then everything
    wait_show_idx(2, 60);
    bus.page_en = 4'b1011;
    step("drop2");
    bus.page_en = 4'b1111;
    run("restore", 3);
    bus.page_en = 4'b0000;
    run("all_off", 3);
    bus.page_en = 4'b1111;
    run("re_on", 3);

    // randomized traffic with occasional mid-operation reset
    for (int c = 0; c < 1500; c++) begin
      bus.hold       = ($urandom_range(0, 3) == 0);
      bus.next_pulse = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) bus.page_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) bus.page_data[$urandom_range(0, NP-1)*DW +: DW] = 16'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        compare("midreset");
        @(negedge clk);
        reset_n = 1'b1;
      end
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
